kme_fail_stop_ctrl: RTL

Failure collector and stop sequencer for the emulation top. It watches a vector of assertion/failure sources, for example the stop and UCF indications. It latches the first failing source and a cycle timestamp, lets the design run a programmable number of drain cycles, then requests a clock stop from the emulator and holds a halted state until software clears it. It replaces the combinational OR of failure sources with a registered, attributable, handshaked stop.

---
 rtl/kme_fail_pkg.sv | 26 ++
 rtl/kme_prio_enc.sv | 23 ++
 rtl/kme_fail_stop_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/kme_fail_pkg.sv
// Shared types and constants for the fail-stop controller.
package kme_fail_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StReq,
        StHalt
    } fail_state_e;

    localparam int unsigned FAIL_CNT_W = 8;
    // Capture fields are sized for the largest supported configuration; the top slices them.
    localparam int unsigned CAP_SRC_W  = 8;
    localparam int unsigned CAP_TS_W   = 64;

    typedef struct packed {
        logic [CAP_SRC_W-1:0] src;
        logic                 multi;
        logic [CAP_TS_W-1:0]  tstamp;
    } fail_cap_t;

    function automatic logic [FAIL_CNT_W-1:0] sat_inc(input logic [FAIL_CNT_W-1:0] v);
        return (v == '1) ? v : v + FAIL_CNT_W'(1);
    endfunction

endpackage

// File: rtl/kme_prio_enc.sv
// Lowest-index priority encoder with any/multi flags.
module kme_prio_enc #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    output logic [IdxW-1:0] idx_o,
    output logic            any_o,
    output logic            multi_o
);

    always_comb begin
        idx_o = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = IdxW'(i);
        end
    end

    assign any_o   = |req_i;
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign multi_o = |(req_i & (req_i - N'(1)));

endmodule

// File: rtl/kme_fail_stop_ctrl.sv
// Failure collector: latches the first unmasked failure, drains, then runs a stop handshake
// with the emulator and holds halted until software clears it.
module kme_fail_stop_ctrl
    import kme_fail_pkg::*;
#(
    parameter int unsigned NUM_SRC      = 4,
    parameter int unsigned DRAIN_CYCLES = 16,
    parameter int unsigned TS_W         = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SRC-1:0]         src_fail,
    input  logic [NUM_SRC-1:0]         src_mask,
    input  logic                       stop_ack,
    input  logic                       clear,
    output logic                       failure,
    output logic [$clog2(NUM_SRC)-1:0] first_src,
    output logic                       first_multi,
    output logic [TS_W-1:0]            fail_time,
    output logic [FAIL_CNT_W-1:0]      fail_count,
    output logic                       stop_req,
    output logic                       halted
);

    localparam int unsigned SrcW   = $clog2(NUM_SRC);
    localparam int unsigned DrainW = (DRAIN_CYCLES == 0) ? 1 : $clog2(DRAIN_CYCLES + 1);

    fail_state_e             state_q, state_d;
    logic [TS_W-1:0]         ts_q, ts_d;
    logic [DrainW-1:0]       drain_q, drain_d;
    fail_cap_t               cap_q, cap_d;
    logic                    failure_q, failure_d;
    logic [FAIL_CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_SRC-1:0]      act;
    logic [SrcW-1:0]         enc_idx;
    logic                    hit;
    logic                    enc_multi;

    assign act = src_fail & ~src_mask;

    kme_prio_enc #(
        .N    (NUM_SRC),
        .IdxW (SrcW)
    ) u_prio_enc (
        .req_i   (act),
        .idx_o   (enc_idx),
        .any_o   (hit),
        .multi_o (enc_multi)
    );

    always_comb begin
        state_d   = state_q;
        ts_d      = ts_q + TS_W'(1);
        drain_d   = drain_q;
        cap_d     = cap_q;
        failure_d = failure_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            StIdle: begin
                // Capture beats a coincident clear: nothing has failed yet.
                if (hit) begin
                    cap_d.src    = CAP_SRC_W'(enc_idx);
                    cap_d.multi  = enc_multi;
                    cap_d.tstamp = CAP_TS_W'(ts_q);
                    failure_d    = 1'b1;
                    cnt_d        = FAIL_CNT_W'(1);
                    drain_d      = DrainW'(DRAIN_CYCLES);
                    state_d      = (DRAIN_CYCLES == 0) ? StReq : StDrain;
                end else if (clear) begin
                    cap_d     = '0;
                    failure_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            StDrain: begin
                if (hit) cnt_d = sat_inc(cnt_q);
                drain_d = drain_q - DrainW'(1);
                if (drain_q == DrainW'(1)) state_d = StReq;
            end
            StReq: begin
                if (hit) cnt_d = sat_inc(cnt_q);
                if (stop_ack) state_d = StHalt;
            end
            StHalt: begin
                if (clear) begin
                    cap_d     = '0;
                    failure_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = StIdle;
                end else if (hit) begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ts_q      <= '0;
            drain_q   <= '0;
            cap_q     <= '0;
            failure_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ts_q      <= ts_d;
            drain_q   <= drain_d;
            cap_q     <= cap_d;
            failure_q <= failure_d;
            cnt_q     <= cnt_d;
        end
    end

    assign failure     = failure_q;
    assign first_src   = cap_q.src[SrcW-1:0];
    assign first_multi = cap_q.multi;
    assign fail_time   = cap_q.tstamp[TS_W-1:0];
    assign fail_count  = cnt_q;
    assign stop_req    = (state_q == StReq);
    assign halted      = (state_q == StHalt);

    if (SrcW < CAP_SRC_W) begin : g_src_pad
        logic unused_src_pad;
        assign unused_src_pad = ^cap_q.src[CAP_SRC_W-1:SrcW];
    end
    if (TS_W < CAP_TS_W) begin : g_ts_pad
        logic unused_ts_pad;
        assign unused_ts_pad = ^cap_q.tstamp[CAP_TS_W-1:TS_W];
    end

endmodule
